// File: rtl/div_ctrl.sv
// div_ctrl: sequencing FSM for the 8-bit by 7-bit shift/subtract divider datapath.
// Build option DIV_CTRL_RESTORING_EN selects the restoring variant (adds a RESTORE state).
module div_ctrl #(
  parameter int NBITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] divisorin,
  input  logic       sign,
  output logic       busy,
  output logic       done,
  output logic       dbz,
  output logic       load,
  output logic       add,
  output logic       shift,
  output logic       inbit,
  output logic [1:0] sel
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

  localparam logic [1:0] SEL_ADDSUB = 2'b01;
  localparam logic [1:0] SEL_LOAD   = 2'b10;
  localparam logic [1:0] SEL_HOLD   = 2'b11;

`ifdef DIV_CTRL_RESTORING_EN
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, TRIAL, RESTORE, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, TRIAL, DONE} state_t;
`endif

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          accept;

  assign accept   = (state == IDLE) && start;
  assign cnt_last = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Counter folds back to zero after the last trial so it never exceeds NBITS-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      dbz <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      dbz <= (divisorin == 7'd0);
    end else if (state == TRIAL) begin
      cnt <= cnt_last ? '0 : cnt + 1'b1;
    end
  end

`ifdef DIV_CTRL_RESTORING_EN
  logic neg_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                neg_q <= 1'b0;
    else if (state == TRIAL)   neg_q <= sign;
    else if (state == RESTORE) neg_q <= 1'b0;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  state_nxt = dbz ? DONE : SHIFT;
      SHIFT: state_nxt = TRIAL;
`ifdef DIV_CTRL_RESTORING_EN
      TRIAL: begin
        if (sign)          state_nxt = RESTORE;
        else if (cnt_last) state_nxt = DONE;
        else               state_nxt = SHIFT;
      end
      // The counter has already advanced in TRIAL; zero means the last bit was done.
      RESTORE: state_nxt = (cnt == '0) ? DONE : SHIFT;
`else
      TRIAL: state_nxt = cnt_last ? DONE : SHIFT;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    done  = (state == DONE);
    load  = 1'b0;
    add   = 1'b0;
    shift = 1'b0;
    inbit = 1'b0;
    sel   = SEL_HOLD;
    case (state)
      LOAD: begin
        load = 1'b1;
        sel  = SEL_LOAD;
      end
      SHIFT: shift = 1'b1;
`ifdef DIV_CTRL_RESTORING_EN
      TRIAL: begin
        sel   = SEL_ADDSUB;
        inbit = 1'b1;
      end
      RESTORE: begin
        add = neg_q;
        sel = neg_q ? SEL_ADDSUB : SEL_HOLD;
      end
`else
      // Non-performing trial: a negative difference is simply not written back.
      TRIAL: begin
        sel   = sign ? SEL_HOLD : SEL_ADDSUB;
        inbit = ~sign;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl with a behavioural model of the divider datapath.
`timescale 1ns/1ps
module tb_div_ctrl;

  localparam int NBITS = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] divisorin = 7'd0;
  logic       sign;
  logic       busy, done, dbz, load, add, shift, inbit;
  logic [1:0] sel;

  logic [7:0]  dividend = 8'd0;
  logic [15:0] rem_q;
  logic [6:0]  dvr_q;
  logic [8:0]  addsub;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  div_ctrl #(.NBITS(NBITS)) dut (
    .clk(clk), .reset(reset), .start(start), .divisorin(divisorin), .sign(sign),
    .busy(busy), .done(done), .dbz(dbz), .load(load), .add(add), .shift(shift),
    .inbit(inbit), .sel(sel)
  );

  always #5 clk = ~clk;

  // Datapath model: 16-bit remainder/quotient register, divisor register, AddSub.
  assign addsub = add ? ({1'b0, rem_q[15:8]} + {2'b00, dvr_q})
                      : ({1'b0, rem_q[15:8]} - {2'b00, dvr_q});
  assign sign = addsub[8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q <= 16'd0;
      dvr_q <= 7'd0;
    end else begin
      if (load) dvr_q <= divisorin;
      case (sel)
        2'b10:   rem_q <= {8'h00, dividend};
        2'b01:   rem_q <= {addsub[7:0], rem_q[7:1], inbit};
        default: if (shift) rem_q <= {rem_q[14:0], 1'b0};
      endcase
    end
  end

  task automatic push_exp(input logic [7:0] dvd, input logic [6:0] dvs);
    exp_t e;
    if (dvs == 7'd0) begin
      e.q = dvd; e.r = 8'd0; e.dz = 1'b1; e.lat = 2;
    end else begin
      e.q = dvd / {1'b0, dvs}; e.r = dvd % {1'b0, dvs}; e.dz = 1'b0; e.lat = 2 * NBITS + 2;
    end
    sb.push_back(e);
  endtask

  // Drives a start request in IDLE and returns just after the sampling edge E0.
  task automatic issue_start(input logic [7:0] dvd, input logic [6:0] dvs);
    @(negedge clk);
    dividend  = dvd;
    divisorin = dvs;
    start     = 1'b1;
    push_exp(dvd, dvs);
    @(posedge clk);
  endtask

  task automatic wait_done(input int budget, input bit hold, input int pulse_at,
                           output int cyc, output int n_sel01, output int n_busy_lo,
                           output int n_shift, output int n_add, output logic dbz_c1,
                           output bit timed_out);
    cyc = 0; n_sel01 = 0; n_busy_lo = 0; n_shift = 0; n_add = 0; dbz_c1 = 1'bx;
    timed_out = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (!hold) start = (c == pulse_at);
      if (sel == 2'b01) n_sel01++;
      if (!busy) n_busy_lo++;
      if (shift) n_shift++;
      if (add) n_add++;
      if (c == 1) dbz_c1 = dbz;
      if (done) begin
        cyc = c;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [8:0] v;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    v = {busy, done, dbz, load, add, shift, inbit, sel};
    tests_run++;
    if (v !== 9'b0000000_11) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected %b", v, 9'b0000000_11);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic_100_7;
    int cyc, n01, nbl, nsh, nad; logic d1; bit to; exp_t e;
    issue_start(8'd100, 7'd7);
    wait_done(40, 1'b0, 6, cyc, n01, nbl, nsh, nad, d1, to);
    e = sb.pop_front();
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL basic_timeout: no done within 40 cycles"); end
    tests_run++;
    if (cyc !== e.lat) begin tests_failed++; $display("FAIL basic_latency: got %0d expected %0d", cyc, e.lat); end
    tests_run++;
    if (rem_q[7:0] !== e.q || rem_q[15:8] !== e.r) begin
      tests_failed++;
      $display("FAIL basic_result: got q=%0d r=%0d expected q=%0d r=%0d", rem_q[7:0], rem_q[15:8], e.q, e.r);
    end
    tests_run++;
    if (dbz !== e.dz) begin tests_failed++; $display("FAIL basic_dbz: got %b expected %b", dbz, e.dz); end
    tests_run++;
    if (nbl !== 0) begin tests_failed++; $display("FAIL basic_busy: busy low in %0d cycles expected 0", nbl); end
    tests_run++;
    if (nsh !== NBITS || nad !== 0) begin
      tests_failed++;
      $display("FAIL basic_ctrl: shifts=%0d adds=%0d expected %0d and 0", nsh, nad, NBITS);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_idle_after: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_all_ones_255_1;
    int cyc, n01, nbl, nsh, nad; logic d1; bit to; exp_t e;
    issue_start(8'd255, 7'd1);
    wait_done(40, 1'b0, 0, cyc, n01, nbl, nsh, nad, d1, to);
    e = sb.pop_front();
    tests_run++;
    if (to || rem_q[7:0] !== e.q || rem_q[15:8] !== e.r) begin
      tests_failed++;
      $display("FAIL div255_1_result: got q=%0d r=%0d timeout=%b expected q=%0d r=%0d", rem_q[7:0], rem_q[15:8], to, e.q, e.r);
    end
    tests_run++;
    if (n01 !== NBITS) begin tests_failed++; $display("FAIL div255_1_sel01: got %0d expected %0d", n01, NBITS); end
  endtask

  task automatic test_all_zeros_5_7;
    int cyc, n01, nbl, nsh, nad; logic d1; bit to; exp_t e;
    issue_start(8'd5, 7'd7);
    wait_done(40, 1'b0, 0, cyc, n01, nbl, nsh, nad, d1, to);
    e = sb.pop_front();
    tests_run++;
    if (to || rem_q[7:0] !== e.q || rem_q[15:8] !== e.r) begin
      tests_failed++;
      $display("FAIL div5_7_result: got q=%0d r=%0d timeout=%b expected q=%0d r=%0d", rem_q[7:0], rem_q[15:8], to, e.q, e.r);
    end
    tests_run++;
    if (n01 !== 0) begin tests_failed++; $display("FAIL div5_7_sel01: got %0d expected 0", n01); end
    tests_run++;
    if (cyc !== e.lat) begin tests_failed++; $display("FAIL div5_7_latency: got %0d expected %0d", cyc, e.lat); end
  endtask

  task automatic test_div_by_zero;
    int cyc, n01, nbl, nsh, nad; logic d1; bit to; exp_t e;
    issue_start(8'd42, 7'd0);
    wait_done(10, 1'b0, 0, cyc, n01, nbl, nsh, nad, d1, to);
    e = sb.pop_front();
    tests_run++;
    if (to || cyc !== e.lat) begin
      tests_failed++;
      $display("FAIL dbz_latency: got %0d timeout=%b expected %0d", cyc, to, e.lat);
    end
    tests_run++;
    if (dbz !== e.dz || rem_q[7:0] !== e.q || rem_q[15:8] !== e.r) begin
      tests_failed++;
      $display("FAIL dbz_result: got dbz=%b q=%0d r=%0d expected dbz=%b q=%0d r=%0d", dbz, rem_q[7:0], rem_q[15:8], e.dz, e.q, e.r);
    end
    @(negedge clk);
    tests_run++;
    if (dbz !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL dbz_held: got dbz=%b busy=%b expected 1 0", dbz, busy);
    end
    issue_start(8'd42, 7'd3);
    wait_done(40, 1'b0, 0, cyc, n01, nbl, nsh, nad, d1, to);
    e = sb.pop_front();
    tests_run++;
    if (d1 !== 1'b0) begin tests_failed++; $display("FAIL dbz_clear: got %b in cycle 1 expected 0", d1); end
    tests_run++;
    if (to || dbz !== e.dz || rem_q[7:0] !== e.q || rem_q[15:8] !== e.r) begin
      tests_failed++;
      $display("FAIL dbz_next_result: got dbz=%b q=%0d r=%0d expected dbz=%b q=%0d r=%0d", dbz, rem_q[7:0], rem_q[15:8], e.dz, e.q, e.r);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, n01, nbl, nsh, nad; logic d1; bit to; exp_t e;
    issue_start(8'd100, 7'd7);
    wait_done(40, 1'b1, 0, cyc, n01, nbl, nsh, nad, d1, to);
    e = sb.pop_front();
    tests_run++;
    if (to || cyc !== e.lat || rem_q[7:0] !== e.q || rem_q[15:8] !== e.r) begin
      tests_failed++;
      $display("FAIL held_first: got cyc=%0d q=%0d r=%0d expected cyc=%0d q=%0d r=%0d", cyc, rem_q[7:0], rem_q[15:8], e.lat, e.q, e.r);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL held_idle_gap: got busy=%b done=%b expected 0 0", busy, done);
    end
    push_exp(8'd100, 7'd7);
    @(posedge clk);
    wait_done(40, 1'b1, 0, cyc, n01, nbl, nsh, nad, d1, to);
    start = 1'b0;
    e = sb.pop_front();
    tests_run++;
    if (to || cyc !== e.lat || rem_q[7:0] !== e.q || rem_q[15:8] !== e.r) begin
      tests_failed++;
      $display("FAIL held_second: got cyc=%0d q=%0d r=%0d expected cyc=%0d q=%0d r=%0d", cyc, rem_q[7:0], rem_q[15:8], e.lat, e.q, e.r);
    end
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL held_no_third: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_midop;
    int cyc, n01, nbl, nsh, nad, ndone; logic d1; bit to; exp_t e;
    logic [8:0] v;
    issue_start(8'd200, 7'd9);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    v = {busy, done, dbz, load, add, shift, inbit, sel};
    sb.delete();
    tests_run++;
    if (v !== 9'b0000000_11) begin
      tests_failed++;
      $display("FAIL midop_reset_outputs: got %b expected %b", v, 9'b0000000_11);
    end
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    tests_run++;
    if (ndone !== 0) begin tests_failed++; $display("FAIL midop_no_done: activity in %0d cycles expected 0", ndone); end
    issue_start(8'd200, 7'd9);
    wait_done(40, 1'b0, 0, cyc, n01, nbl, nsh, nad, d1, to);
    e = sb.pop_front();
    tests_run++;
    if (to || cyc !== e.lat || rem_q[7:0] !== e.q || rem_q[15:8] !== e.r) begin
      tests_failed++;
      $display("FAIL midop_rerun: got cyc=%0d q=%0d r=%0d expected cyc=%0d q=%0d r=%0d", cyc, rem_q[7:0], rem_q[15:8], e.lat, e.q, e.r);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_100_7();
    test_all_ones_255_1();
    test_all_zeros_5_7();
    test_div_by_zero();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller for the 8-bit by 7-bit shift/subtract divider datapath.
- Accepts a start request, loads divisor and dividend, then runs NBITS shift/trial-subtract iterations through the datapath control lines and signals completion.
- Sits between the bus-facing top level and the datapath. The controller owns the iteration counter and the handshake.

Parameters:
- NBITS, 8, number of quotient bits and iterations; counter width is ceil(log2(NBITS)).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request a divide; sampled only in IDLE
- divisorin  input  7  divisor operand, used only for zero detect at start
- sign  input  1  datapath AddSub MSB; 1 = trial result negative
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; quotient and remainder are valid on the datapath
- dbz  output  1  divide-by-zero flag; held until the next accepted start
- load  output  1  datapath: capture divisorin into the divisor register
- add  output  1  datapath: 1 = add divisor, 0 = subtract divisor
- shift  output  1  datapath: shift the 16-bit remainder register left, bit0 <= 0
- inbit  output  1  datapath: value written into register bit0 when sel=01
- sel  output  2  datapath mux: 10 = load {0, dividend}; 01 = upper <= AddSub, bit0 <= inbit; 11 = hold/shift

Behaviour:
- Reset (async, active-low):
  - State = IDLE, counter = 0.
  - busy, done, dbz, load, add, shift, inbit = 0; sel = 11.
- Default outputs in any state not listed below: load=0, add=0, shift=0, inbit=0, sel=11.
- IDLE:
  - On start=1, go to LOAD.
  - Capture dbz = (divisorin == 0) and clear counter.
- LOAD (1 cycle):
  - load=1, sel=10.
  - Next state: DONE if dbz=1, else SHIFT.
- SHIFT (1 cycle):
  - shift=1, sel=11.
  - Next state: TRIAL.
- TRIAL (1 cycle, Mealy on sign):
  - Drive add=0.
  - If sign=0: sel=01, inbit=1 (commit difference, quotient bit = 1).
  - If sign=1: sel=11, inbit=0 (no write; bit0 is already 0 from the shift).
  - Counter increments.
  - If counter == NBITS-1, go to DONE; otherwise go to SHIFT.
- DONE (1 cycle):
  - done=1, busy=1.
  - Next state: IDLE unconditionally.
  - start during DONE is ignored; the requester must re-assert start in IDLE.
- Latency, non-zero divisor: start sampled at edge E0 gives LOAD in cycle 1, 2*NBITS iteration cycles, and done in cycle 2*NBITS+2 (18 for NBITS=8). The next start can be accepted in cycle 2*NBITS+3.
- Divide by zero: done in cycle 2 and dbz=1. The datapath quotient equals the dividend and the remainder is 0; these values are defined, not an error.
- start while busy: ignored, with no effect on state or counter.
- Reset mid-operation: returns to IDLE immediately and no done pulse is issued. The datapath is reset by the same signal.
- Counter wrap: the counter never exceeds NBITS-1. After DONE it is cleared at the next accepted start.
- All control outputs except TRIAL sel/inbit are decoded from state only. TRIAL sel/inbit are combinational from sign.
- No glitch requirement beyond single-clock synchronous design.

Optional Feature:
- Macro: DIV_CTRL_RESTORING_EN.
- Defined: restoring algorithm.
  - TRIAL always commits: sel=01, add=0, inbit=1. It registers sign into neg_q.
  - If neg_q=1, the next state is RESTORE instead of SHIFT/DONE.
  - RESTORE: sel=01, add=1, inbit=0. It then goes to SHIFT, or to DONE when the counter is exhausted.
  - The counter increments in TRIAL in both modes.
  - Latency: 2*NBITS+2 cycles plus 1 cycle per zero quotient bit.
- Undefined: non-performing single-cycle TRIAL as specified above; the RESTORE state does not exist.
- The port list is identical in both builds.

Test Plan:
- 100 / 7, start pulse in IDLE -> done exactly 18 cycles after the start edge; quotient = 14, remainder = 2, dbz = 0, busy high for cycles 1-18.
- 255 / 1 -> quotient = 255, remainder = 0; TRIAL always takes sign=0, so sel=01 is seen 8 times.
- 5 / 7 -> quotient = 0, remainder = 5; sel never equals 01 after LOAD.
- Divisor 0, dividend 42 -> done in cycle 2, dbz = 1, quotient = 42; dbz clears on the next start with divisor 3.
- start held high continuously through a 100/7 op -> exactly one done pulse per operation; the second op begins only from IDLE (cycle 19); start pulses mid-op are ignored.
- reset low at cycle 9 of a 200/9 op -> all outputs return to reset values asynchronously; no done pulse; a subsequent 200/9 yields quotient = 22, remainder = 2.
